calc_core: RTL and testbench

- Calculator engine directly downstream of the keypad scanner. It consumes one-shot key events (digit or operator code) and builds decimal operands.
- Executes add/subtract/multiply/divide with chaining, and drives a signed value plus error flag to the display stage.
- Division is an iterative restoring divider; all other operations finish in one cycle.

---
 rtl/calc_if.sv | 16 +
 rtl/calc_core.sv | 221 ++++++++++++++++++++++
 tb/tb_calc_core.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_if.sv
// Key-event and display bundle between the keypad scanner, calc_core and the display stage.
interface calc_if #(parameter int WIDTH = 16);
  logic             key_valid;
  logic [3:0]       key_digit;
  logic [3:0]       key_oper;
  logic [WIDTH-1:0] display_mag;
  logic             display_neg;
  logic             error;
  logic             busy;
  logic             result_valid;

  modport master (output key_valid, key_digit, key_oper,
                  input  display_mag, display_neg, error, busy, result_valid);
  modport slave  (input  key_valid, key_digit, key_oper,
                  output display_mag, display_neg, error, busy, result_valid);
endinterface

// File: rtl/calc_core.sv
// Calculator engine: decimal operand entry, chained add/sub/mul and an iterative restoring divider.
// Optional KEY_FIFO_EN: 2-entry queue that replays key events arriving while busy.
//   state   | meaning
//   ENTRY_A | building first operand in acc
//   ENTRY_B | opA and op latched, building second operand in acc
//   COMPUTE | executing op_q on opA and acc (busy)
//   SHOW    | result displayed
//   ERR     | overflow or divide by zero, only clear exits
module calc_core #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input logic   clk,
  input logic   rst,
  calc_if.slave bus
);
  typedef enum logic [2:0] {ENTRY_A, ENTRY_B, COMPUTE, SHOW, ERR} state_t;

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int SW = $clog2(WIDTH);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_DIGITS);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);
  localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3, OP_DIV = 4'd4;
  localparam logic [3:0] OP_CLR = 4'd5, OP_EQ = 4'd6;

  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, res_q, res_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, mag_q, mag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] step_q, step_d;
  logic [3:0] op_q, op_d, nop_q, nop_d;
  logic dig_q, dig_d, chain_q, chain_d, neg_q, neg_d;
  logic err_q, err_d, busy_q, busy_d, rv_q, rv_d;

  logic live_ok, ev_valid;
  logic [3:0] ev_oper, ev_digit;

  assign live_ok = bus.key_valid &&
                   ((bus.key_oper == 4'd0) ? (bus.key_digit <= 4'd9) : (bus.key_oper <= OP_EQ));

`ifdef KEY_FIFO_EN
  logic [7:0] f0_q, f0_d, f1_q, f1_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic pop, push, flush;

  // Once anything is queued, live keys also go through the queue to keep order.
  always_comb begin
    pop      = (fcnt_q != 2'd0) && (state_q != COMPUTE);
    push     = live_ok && ((state_q == COMPUTE) || (fcnt_q != 2'd0));
    ev_valid = pop || (live_ok && (state_q != COMPUTE));
    {ev_oper, ev_digit} = pop ? f0_q : {bus.key_oper, bus.key_digit};
    flush    = ev_valid && (ev_oper == OP_CLR);
    fcnt_d   = fcnt_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    if (pop) begin
      f0_d   = f1_q;
      fcnt_d = fcnt_q - 2'd1;
    end
    if (push && (fcnt_d != 2'd2)) begin
      if (fcnt_d == 2'd0) f0_d = {bus.key_oper, bus.key_digit};
      else                f1_d = {bus.key_oper, bus.key_digit};
      fcnt_d = fcnt_d + 2'd1;
    end
    if (flush) fcnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= 2'd0;
      f0_q   <= 8'd0;
      f1_q   <= 8'd0;
    end else begin
      fcnt_q <= fcnt_d;
      f0_q   <= f0_d;
      f1_q   <= f1_d;
    end
  end
`else
  assign ev_valid = live_ok && (state_q != COMPUTE);
  assign ev_oper  = bus.key_oper;
  assign ev_digit = bus.key_digit;
`endif

  logic [2*WIDTH-1:0] a_ext, b_ext, full, q_ext;
  logic [WIDTH:0] trial, diff, hi;
  logic [WIDTH-1:0] show_val;
  logic qbit, done, div0, ovf;

  always_comb begin
    state_d = state_q;  acc_d  = acc_q;  opa_d  = opa_q;  res_d = res_q;
    rem_d   = rem_q;    quo_d  = quo_q;  cnt_d  = cnt_q;  step_d = step_q;
    op_d    = op_q;     nop_d  = nop_q;  dig_d  = dig_q;  chain_d = chain_q;
    rv_d    = 1'b0;
    a_ext   = {{WIDTH{opa_q[WIDTH-1]}}, opa_q};
    b_ext   = {{WIDTH{1'b0}}, acc_q};
    full    = '0;
    trial   = {rem_q, quo_q[WIDTH-1]};
    diff    = trial - {1'b0, acc_q};
    qbit    = 1'b0;
    q_ext   = '0;
    done    = 1'b0;
    div0    = 1'b0;
    if (ev_valid && (ev_oper == OP_CLR)) begin
      state_d = ENTRY_A; acc_d = '0; opa_d = '0; res_d = '0; cnt_d = '0;
      op_d = '0; nop_d = '0; dig_d = 1'b0; chain_d = 1'b0;
    end else begin
      case (state_q)
        ENTRY_A, ENTRY_B: if (ev_valid) begin
          if (ev_oper == 4'd0) begin
            if (cnt_q < MAX_CNT) begin
              acc_d = acc_q * WIDTH'(10) + WIDTH'(ev_digit);
              if (!((acc_q == '0) && (ev_digit == 4'd0))) cnt_d = cnt_q + CW'(1);
            end
            if (state_q == ENTRY_B) dig_d = 1'b1;
          end else if (ev_oper <= OP_DIV) begin
            if (state_q == ENTRY_A) begin
              opa_d = acc_q; op_d = ev_oper; acc_d = '0; cnt_d = '0; dig_d = 1'b0;
              state_d = ENTRY_B;
            end else if (!dig_q) begin
              op_d = ev_oper;
            end else begin
              nop_d = ev_oper; chain_d = 1'b1; state_d = COMPUTE;
            end
          end else if ((ev_oper == OP_EQ) && (state_q == ENTRY_B)) begin
            chain_d = 1'b0; state_d = COMPUTE;
          end
          // Divider is primed on entry so the divide occupies exactly WIDTH cycles.
          if (state_d == COMPUTE) begin
            step_d = '0;
            rem_d  = '0;
            quo_d  = opa_q[WIDTH-1] ? -opa_q : opa_q;
          end
        end
        COMPUTE: begin
          step_d = step_q + SW'(1);
          case (op_q)
            OP_ADD: begin full = a_ext + b_ext; done = 1'b1; end
            OP_SUB: begin full = a_ext - b_ext; done = 1'b1; end
            OP_MUL: begin full = a_ext * b_ext; done = 1'b1; end
            default: begin
              div0 = (acc_q == '0);
              if (!trial[WIDTH] && (trial < {1'b0, acc_q})) begin
                rem_d = trial[WIDTH-1:0];
              end else begin
                rem_d = diff[WIDTH-1:0];
                qbit  = 1'b1;
              end
              quo_d = {quo_q[WIDTH-2:0], qbit};
              q_ext = {{WIDTH{1'b0}}, quo_d};
              full  = opa_q[WIDTH-1] ? -q_ext : q_ext;
              done  = (step_q == LAST_STEP);
            end
          endcase
          if (div0 || (done && ovf)) begin
            state_d = ERR;
          end else if (done) begin
            res_d = full[WIDTH-1:0];
            rv_d  = 1'b1;
            if (chain_q) begin
              opa_d = full[WIDTH-1:0]; op_d = nop_q; acc_d = '0; cnt_d = '0; dig_d = 1'b0;
              state_d = ENTRY_B;
            end else begin
              state_d = SHOW;
            end
          end
        end
        SHOW: if (ev_valid) begin
          if (ev_oper == 4'd0) begin
            acc_d = WIDTH'(ev_digit); cnt_d = CW'(ev_digit != 4'd0); dig_d = 1'b0;
            state_d = ENTRY_A;
          end else if (ev_oper <= OP_DIV) begin
            opa_d = res_q; op_d = ev_oper; acc_d = '0; cnt_d = '0; dig_d = 1'b0;
            state_d = ENTRY_B;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi  = full[2*WIDTH-1:WIDTH-1];
  assign ovf = !((&hi) || (~|hi));

  always_comb begin
    show_val = '0;
    mag_d    = mag_q;
    neg_d    = neg_q;
    case (state_d)
      ENTRY_A: show_val = acc_d;
      ENTRY_B: show_val = ((cnt_d != '0) || dig_d) ? acc_d : opa_d;
      SHOW:    show_val = res_d;
      default: show_val = '0;
    endcase
    if (state_d != COMPUTE) begin
      neg_d = show_val[WIDTH-1];
      mag_d = show_val[WIDTH-1] ? -show_val : show_val;
    end
    err_d  = (state_d == ERR);
    busy_d = (state_d == COMPUTE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY_A; acc_q <= '0; opa_q <= '0; res_q <= '0; rem_q <= '0; quo_q <= '0;
      cnt_q <= '0; step_q <= '0; op_q <= '0; nop_q <= '0; dig_q <= 1'b0; chain_q <= 1'b0;
      mag_q <= '0; neg_q <= 1'b0; err_q <= 1'b0; busy_q <= 1'b0; rv_q <= 1'b0;
    end else begin
      state_q <= state_d; acc_q <= acc_d; opa_q <= opa_d; res_q <= res_d; rem_q <= rem_d;
      quo_q <= quo_d; cnt_q <= cnt_d; step_q <= step_d; op_q <= op_d; nop_q <= nop_d;
      dig_q <= dig_d; chain_q <= chain_d; mag_q <= mag_d; neg_q <= neg_d; err_q <= err_d;
      busy_q <= busy_d; rv_q <= rv_d;
    end
  end

  assign bus.display_mag  = mag_q;
  assign bus.display_neg  = neg_q;
  assign bus.error        = err_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: key-press vector table with a scoreboard queue,
// plus hand sequences for busy length, result_valid counts, keys during divide and reset mid-divide.
module tb_calc_core;
  localparam int W = 16;
  localparam logic [3:0] K_DIG = 4'd0, K_ADD = 4'd1, K_SUB = 4'd2, K_MUL = 4'd3;
  localparam logic [3:0] K_DIV = 4'd4, K_CLR = 4'd5, K_EQ = 4'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  calc_if #(.WIDTH(W)) bus ();
  calc_core #(.WIDTH(W), .MAX_DIGITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   oper;
    logic [3:0]   digit;
    logic [W-1:0] mag;
    logic         neg;
    logic         err;
  } vec_t;
  typedef struct {
    logic [W-1:0] mag;
    logic         neg;
    logic         err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0, failures = 0;
  int busy_cycles = 0, rv_pulses = 0;

  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_cycles++;
    if (bus.result_valid === 1'b1) rv_pulses++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic v(input logic [3:0] o, input logic [3:0] d, input int m, input logic n, input logic e);
    vec_t r;
    r.oper = o; r.digit = d; r.mag = m[W-1:0]; r.neg = n; r.err = e;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic [3:0] oper, input logic [3:0] digit);
    bus.key_valid = 1'b1; bus.key_oper = oper; bus.key_digit = digit;
    @(negedge clk);
    bus.key_valid = 1'b0; bus.key_oper = 4'd0; bus.key_digit = 4'd0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bus.busy !== 1'b0) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic key(input logic [3:0] oper, input logic [3:0] digit);
    drive(oper, digit);
    wait_idle("key");
  endtask

  task automatic num(input int n);
    if (n >= 1000) key(K_DIG, 4'((n / 1000) % 10));
    if (n >= 100)  key(K_DIG, 4'((n / 100) % 10));
    if (n >= 10)   key(K_DIG, 4'((n / 10) % 10));
    key(K_DIG, 4'(n % 10));
  endtask

  task automatic chk_disp(input string name, input int m, input logic n, input logic e);
    exp_t x;
    x.mag = m[W-1:0]; x.neg = n; x.err = e;
    sb.push_back(x);
    x = sb.pop_front();
    chk({name, "_mag"}, {16'd0, bus.display_mag}, {16'd0, x.mag});
    chk({name, "_neg"}, {31'd0, bus.display_neg}, {31'd0, x.neg});
    chk({name, "_err"}, {31'd0, bus.error}, {31'd0, x.err});
  endtask

  initial begin
    int b0, r0;
    exp_t e;
    bus.key_valid = 1'b0; bus.key_oper = 4'd0; bus.key_digit = 4'd0;

    v(K_DIG,1,1,0,0); v(K_DIG,2,12,0,0); v(K_ADD,0,12,0,0); v(K_DIG,3,3,0,0);
    v(K_DIG,4,34,0,0); v(K_EQ,0,46,0,0);
    v(K_DIG,5,5,0,0); v(K_SUB,0,5,0,0); v(K_DIG,9,9,0,0); v(K_EQ,0,4,1,0);
    v(K_MUL,0,4,1,0); v(K_DIG,2,2,0,0); v(K_EQ,0,8,1,0); v(K_CLR,0,0,0,0);
    v(K_DIG,1,1,0,0); v(K_DIG,0,10,0,0); v(K_DIG,0,100,0,0); v(K_DIV,0,100,0,0);
    v(K_DIG,7,7,0,0); v(K_EQ,0,14,0,0);
    v(K_DIG,7,7,0,0); v(K_DIV,0,7,0,0); v(K_DIG,0,0,0,0); v(K_EQ,0,0,0,1);
    v(K_DIG,3,0,0,1); v(K_ADD,0,0,0,1); v(K_CLR,0,0,0,0);
    v(K_DIG,9,9,0,0); v(K_DIG,9,99,0,0); v(K_DIG,9,999,0,0); v(K_DIG,9,9999,0,0);
    v(K_DIG,9,9999,0,0); v(K_MUL,0,9999,0,0);
    v(K_DIG,9,9,0,0); v(K_DIG,9,99,0,0); v(K_DIG,9,999,0,0); v(K_DIG,9,9999,0,0);
    v(K_EQ,0,0,0,1); v(K_CLR,0,0,0,0);
    v(K_DIG,1,1,0,0); v(K_DIG,2,12,0,0); v(K_DIG,3,123,0,0); v(K_DIG,4,1234,0,0);
    v(K_DIG,5,1234,0,0); v(K_CLR,0,0,0,0);
    v(K_DIG,0,0,0,0); v(K_DIG,0,0,0,0); v(K_DIG,7,7,0,0); v(K_DIG,1,71,0,0);
    v(K_DIG,2,712,0,0); v(K_DIG,3,7123,0,0); v(K_DIG,4,7123,0,0); v(K_CLR,0,0,0,0);
    v(K_DIG,2,2,0,0); v(K_ADD,0,2,0,0); v(K_DIG,3,3,0,0); v(K_MUL,0,5,0,0);
    v(K_DIG,4,4,0,0); v(K_EQ,0,20,0,0); v(K_CLR,0,0,0,0);
    v(K_DIG,6,6,0,0); v(K_ADD,0,6,0,0); v(K_SUB,0,6,0,0); v(K_DIG,2,2,0,0); v(K_EQ,0,4,0,0);
    v(4'd7,0,4,0,0); v(K_DIG,4'd12,4,0,0); v(K_EQ,0,4,0,0); v(K_CLR,0,0,0,0);
    v(K_DIG,5,5,0,0); v(K_EQ,0,5,0,0); v(K_ADD,0,5,0,0); v(K_EQ,0,5,0,0);
    v(K_DIV,0,5,0,0); v(K_EQ,0,0,0,1); v(K_CLR,0,0,0,0);
    v(K_DIG,3,3,0,0); v(K_DIG,2,32,0,0); v(K_DIG,7,327,0,0); v(K_DIG,6,3276,0,0);
    v(K_MUL,0,3276,0,0); v(K_DIG,1,1,0,0); v(K_DIG,0,10,0,0); v(K_ADD,0,32760,0,0);
    v(K_DIG,7,7,0,0); v(K_ADD,0,32767,0,0); v(K_DIG,1,1,0,0); v(K_EQ,0,0,0,1);
    v(K_CLR,0,0,0,0);
    v(K_DIG,0,0,0,0); v(K_SUB,0,0,0,0); v(K_DIG,3,3,0,0); v(K_DIG,2,32,0,0);
    v(K_DIG,7,327,0,0); v(K_DIG,6,3276,0,0); v(K_MUL,0,3276,1,0); v(K_DIG,1,1,0,0);
    v(K_DIG,0,10,0,0); v(K_SUB,0,32760,1,0); v(K_DIG,8,8,0,0); v(K_EQ,0,32768,1,0);
    v(K_DIV,0,32768,1,0); v(K_DIG,3,3,0,0); v(K_EQ,0,10922,1,0); v(K_CLR,0,0,0,0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_disp("reset", 0, 1'b0, 1'b0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_rv", {31'd0, bus.result_valid}, 32'd0);

    foreach (vecs[i]) begin
      e.mag = vecs[i].mag; e.neg = vecs[i].neg; e.err = vecs[i].err;
      sb.push_back(e);
      key(vecs[i].oper, vecs[i].digit);
      e = sb.pop_front();
      chk($sformatf("vec%0d_mag", i), {16'd0, bus.display_mag}, {16'd0, e.mag});
      chk($sformatf("vec%0d_neg", i), {31'd0, bus.display_neg}, {31'd0, e.neg});
      chk($sformatf("vec%0d_err", i), {31'd0, bus.error}, {31'd0, e.err});
    end

    // add: one busy cycle, one result_valid pulse
    b0 = busy_cycles; r0 = rv_pulses;
    num(12); key(K_ADD, 0); num(34); key(K_EQ, 0);
    repeat (2) @(negedge clk);
    chk("add_busy_cycles", busy_cycles - b0, 32'd1);
    chk("add_rv_pulses", rv_pulses - r0, 32'd1);
    chk_disp("add_seq", 46, 1'b0, 1'b0);
    key(K_CLR, 0);

    // divide: exactly W busy cycles
    b0 = busy_cycles; r0 = rv_pulses;
    num(100); key(K_DIV, 0); num(7); key(K_EQ, 0);
    repeat (2) @(negedge clk);
    chk("div_busy_cycles", busy_cycles - b0, 32'(W));
    chk("div_rv_pulses", rv_pulses - r0, 32'd1);
    chk_disp("div_seq", 14, 1'b0, 1'b0);
    key(K_CLR, 0);

    // overflow: error without result_valid
    r0 = rv_pulses;
    num(9999); key(K_MUL, 0); num(9999); key(K_EQ, 0);
    repeat (2) @(negedge clk);
    chk("ovf_rv_pulses", rv_pulses - r0, 32'd0);
    chk_disp("ovf_seq", 0, 1'b0, 1'b1);
    key(K_CLR, 0);

    // chain: one pulse per computation
    r0 = rv_pulses;
    num(2); key(K_ADD, 0); num(3); key(K_MUL, 0); num(4); key(K_EQ, 0);
    repeat (2) @(negedge clk);
    chk("chain_rv_pulses", rv_pulses - r0, 32'd2);
    chk_disp("chain_seq", 20, 1'b0, 1'b0);
    key(K_CLR, 0);

    // keys during a divide
    num(100); key(K_DIV, 0); num(7);
    drive(K_EQ, 0);
    chk("div_busy_on_entry", {31'd0, bus.busy}, 32'd1);
    drive(K_DIG, 4'd3);
    drive(K_CLR, 0);
    wait_idle("div_keys");
    repeat (4) @(negedge clk);
`ifdef KEY_FIFO_EN
    chk_disp("div_keys_queued", 0, 1'b0, 1'b0);
`else
    chk_disp("div_keys_dropped", 14, 1'b0, 1'b0);
`endif
    key(K_CLR, 0);

    // reset mid-divide
    num(100); key(K_DIV, 0); num(7);
    drive(K_EQ, 0);
    repeat (3) @(negedge clk);
    r0 = rv_pulses;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstdiv_busy", {31'd0, bus.busy}, 32'd0);
    chk_disp("rstdiv", 0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("rstdiv_rv_pulses", rv_pulses - r0, 32'd0);
    key(K_DIG, 4'd5);
    chk_disp("rstdiv_after", 5, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
